gmii_rx_framer: RTL and testbench

Parametrised GMII receive framer between the RGMII-to-GMII converter's receive side and the packet logic. It strips preamble and SFD, checks CRC-32, validates length, filters the destination MAC and removes the FCS. It streams payload bytes with start-of-frame and per-frame status, replacing the fixed-function receive path of the first-generation Ethernet test. All logic runs in the GMII receive clock domain.

---
 rtl/gmii_rx_framer.sv | 249 ++++++++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32, length and destination
// address, removes the FCS and streams the payload with per-frame status.
module gmii_rx_framer #(
    parameter logic [47:0] LOCAL_MAC    = 48'h000A35_010203,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter bit          PROMISC      = 1'b0,
    parameter int unsigned MIN_LEN      = 64,
    parameter int unsigned MAX_LEN      = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_done,
    output logic        out_good,
    output logic [3:0]  out_status,
    output logic [15:0] out_len,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [15:0] MIN_L       = MIN_LEN[15:0];
    localparam logic [15:0] MAX_L       = MAX_LEN[15:0];

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_BODY,
        S_DISCARD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            dv_q, er_q, primed_q;
    logic [7:0]      rxd_q;
    logic [15:0]     cnt_q, cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic [47:0]     da_q, da_d;
    logic [3:0][7:0] dly_q, dly_d;
    logic            sof_pend_q, sof_pend_d;
    logic            ovf_q, ovf_d;
    logic            pre_err_q, pre_err_d;
    logic            gerr_q, gerr_d;

    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            done_q, done_d;
    logic            good_q, good_d;
    logic [3:0]      status_q, status_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     sgood_q, sgood_d;
    logic [15:0]     sbad_q, sbad_d;

    logic            finish;
    logic            addr_miss_c, len_err_c, crc_err_c;
    logic [3:0]      status_c;
    logic [15:0]     len_c;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Frame verdict, sampled only on the cycle the frame closes.
    always_comb begin
        addr_miss_c = (cnt_q < 16'd6) ||
                      !(PROMISC || (da_q == LOCAL_MAC) ||
                        (ACCEPT_BCAST && (da_q == {48{1'b1}})));
        len_err_c   = pre_err_q || ovf_q || (cnt_q < MIN_L) || (cnt_q > MAX_L);
        crc_err_c   = (crc_q != CRC_RESIDUE);
        status_c    = {addr_miss_c, len_err_c, gerr_q, crc_err_c};
        if (cnt_q > MAX_L) begin
            len_c = MAX_L - 16'd4;
        end else if (cnt_q >= 16'd4) begin
            len_c = cnt_q - 16'd4;
        end else begin
            len_c = 16'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        da_d       = da_q;
        dly_d      = dly_q;
        sof_pend_d = sof_pend_q;
        ovf_d      = ovf_q;
        pre_err_d  = pre_err_q;
        gerr_d     = gerr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        done_d     = 1'b0;
        good_d     = good_q;
        status_d   = status_q;
        len_d      = len_q;
        sgood_d    = sgood_q;
        sbad_d     = sbad_q;
        finish     = 1'b0;

        unique case (state_q)
            S_WAIT_IDLE: begin
                if (primed_q && !dv_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (dv_q && rxd_q == 8'h55) state_d = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = S_IDLE;
                end else if (rxd_q == 8'hD5) begin
                    state_d    = S_BODY;
                    cnt_d      = 16'd0;
                    crc_d      = 32'hFFFF_FFFF;
                    gerr_d     = 1'b0;
                    ovf_d      = 1'b0;
                    pre_err_d  = 1'b0;
                    sof_pend_d = 1'b1;
                end else if (rxd_q != 8'h55) begin
                    state_d   = S_DISCARD;
                    cnt_d     = 16'd0;
                    crc_d     = 32'hFFFF_FFFF;
                    gerr_d    = 1'b0;
                    ovf_d     = 1'b0;
                    pre_err_d = 1'b1;
                end
            end
            S_BODY: begin
                if (!dv_q) begin
                    finish = 1'b1;
                end else begin
                    cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    crc_d  = crc_step(crc_q, rxd_q);
                    gerr_d = gerr_q | er_q;
                    dly_d  = {dly_q[2:0], rxd_q};
                    if (cnt_q < 16'd6) da_d = {da_q[39:0], rxd_q};
                    // The byte that pushes the count past MAX_LEN is never released.
                    if (cnt_q >= MAX_L) begin
                        state_d = S_DISCARD;
                        ovf_d   = 1'b1;
                    end else if (cnt_q >= 16'd4) begin
                        valid_d    = 1'b1;
                        data_d     = dly_q[3];
                        sof_d      = sof_pend_q;
                        sof_pend_d = 1'b0;
                    end
                end
            end
            S_DISCARD: begin
                if (!dv_q) begin
                    finish = 1'b1;
                end else if (er_q && !pre_err_q) begin
                    gerr_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = (dv_q && rxd_q == 8'h55) ? S_PREAMBLE : S_IDLE;
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        if (finish) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            good_d   = (status_c == 4'b0000);
            status_d = status_c;
            len_d    = len_c;
            if (status_c == 4'b0000) begin
                sgood_d = sgood_q + 16'd1;
            end else begin
                sbad_d = sbad_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_IDLE;
            dv_q       <= 1'b0;
            er_q       <= 1'b0;
            primed_q   <= 1'b0;
            cnt_q      <= 16'd0;
            sof_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            pre_err_q  <= 1'b0;
            gerr_q     <= 1'b0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            done_q     <= 1'b0;
            good_q     <= 1'b0;
            status_q   <= 4'd0;
            len_q      <= 16'd0;
            sgood_q    <= 16'd0;
            sbad_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            dv_q       <= gmii_rx_dv;
            er_q       <= gmii_rx_er;
            primed_q   <= 1'b1;
            cnt_q      <= cnt_d;
            sof_pend_q <= sof_pend_d;
            ovf_q      <= ovf_d;
            pre_err_q  <= pre_err_d;
            gerr_q     <= gerr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            done_q     <= done_d;
            good_q     <= good_d;
            status_q   <= status_d;
            len_q      <= len_d;
            sgood_q    <= sgood_d;
            sbad_q     <= sbad_d;
        end
    end

    // Pure datapath: always rewritten by the FSM before it is consumed.
    always_ff @(posedge clk) begin
        rxd_q <= gmii_rxd;
        crc_q <= crc_d;
        da_q  <= da_d;
        dly_q <= dly_d;
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_sof    = sof_q;
    assign out_done   = done_q;
    assign out_good   = good_q;
    assign out_status = status_q;
    assign out_len    = len_q;
    assign stat_good  = sgood_q;
    assign stat_bad   = sbad_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized bench for gmii_rx_framer: frames are built with a true CRC-32 and
// every result is predicted by a frame-level reference model.
module tb_gmii_rx_framer;

    localparam logic [47:0] MAC  = 48'h000A35_010203;
    localparam int          MAXL = 1518;
    localparam int          MINL = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        dv, er;

    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_done, out_good;
    logic [3:0]  out_status;
    logic [15:0] out_len, stat_good, stat_bad;

    logic [7:0]  d1_data, d2_data;
    logic        d1_valid, d1_sof, d1_done, d1_good;
    logic        d2_valid, d2_sof, d2_done, d2_good;
    logic [3:0]  d1_status, d2_status;
    logic [15:0] d1_len, d1_sg, d1_sb, d2_len, d2_sg, d2_sb;

    gmii_rx_framer dut (
        .clk(clk), .rst_n(rst_n), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_done(out_done),
        .out_good(out_good), .out_status(out_status), .out_len(out_len),
        .stat_good(stat_good), .stat_bad(stat_bad));

    gmii_rx_framer #(.ACCEPT_BCAST(1'b0)) dut_nobcast (
        .clk(clk), .rst_n(rst_n), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
        .out_data(d1_data), .out_valid(d1_valid), .out_sof(d1_sof), .out_done(d1_done),
        .out_good(d1_good), .out_status(d1_status), .out_len(d1_len),
        .stat_good(d1_sg), .stat_bad(d1_sb));

    gmii_rx_framer #(.PROMISC(1'b1)) dut_promisc (
        .clk(clk), .rst_n(rst_n), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
        .out_data(d2_data), .out_valid(d2_valid), .out_sof(d2_sof), .out_done(d2_done),
        .out_good(d2_good), .out_status(d2_status), .out_len(d2_len),
        .stat_good(d2_sg), .stat_bad(d2_sb));

    always #4 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  st0, st1, st2;
        logic        good;
        logic [15:0] len;
        int          nb;
        longint      first_cyc;
        longint      done_cyc;
        bit          sof_ok;
    } rec_t;

    typedef struct {
        logic [3:0]  st;
        logic        good;
        logic [15:0] len;
    } aux_t;

    rec_t         exp_q[$], res_q[$];
    aux_t         aux1_q[$], aux2_q[$];
    byte unsigned rx_bytes[$], exp_bytes[$];
    int           valid_cnt = 0, done_cnt = 0, stream_diff = 0;
    int           exp_good = 0, exp_bad = 0;
    int           n_total = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Standard Ethernet CRC-32 of the first n bytes (init all-ones, final invert).
    function automatic logic [31:0] crc32(input byte unsigned d[$], input int n);
        logic [31:0]  c;
        byte unsigned x;
        logic         fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            x = d[i];
            for (int b = 0; b < 8; b++) begin
                fb = x[b] ^ c[0];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic logic [3:0] model_status(input byte unsigned f[$], input int er_idx,
                                                input bit bcast, input bit promisc);
        int          len, cnt;
        logic [47:0] da;
        logic [31:0] fcs;
        bit          miss, lerr, gerr, cerr;
        len = f.size();
        cnt = (len > MAXL) ? MAXL + 1 : len;
        da  = '0;
        if (len >= 6) for (int i = 0; i < 6; i++) da = {da[39:0], f[i]};
        miss = (len < 6) || !(promisc || da == MAC || (bcast && da == {48{1'b1}}));
        lerr = (len > MAXL) || (len < MINL);
        gerr = (er_idx >= 0) && (er_idx < len);
        if (cnt < 4) begin
            cerr = 1'b1;
        end else begin
            fcs  = {f[cnt-1], f[cnt-2], f[cnt-3], f[cnt-4]};
            cerr = (crc32(f, cnt - 4) != fcs);
        end
        return {miss, lerr, gerr, cerr};
    endfunction

    task automatic make_frame(output byte unsigned f[$], input logic [47:0] da,
                              input int blen, input bit good_fcs);
        logic [31:0] c;
        f = {};
        for (int i = 0; i < 6; i++) f.push_back(da[47-8*i -: 8]);
        while (f.size() < blen - 4) f.push_back(8'($urandom));
        c = crc32(f, f.size());
        if (!good_fcs) c = ~c;
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        f.push_back(c[23:16]);
        f.push_back(c[31:24]);
    endtask

    task automatic send_frame(input byte unsigned f[$], input int npre, input int er_idx,
                              input int gap);
        rec_t   e;
        longint t4;
        int     len, n;
        len = f.size();
        t4  = -1;
        for (int i = 0; i < npre; i++) begin
            @(negedge clk);
            dv = 1'b1; rxd = 8'h55; er = 1'b0;
        end
        @(negedge clk);
        rxd = 8'hD5;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            rxd = f[k];
            er  = (k == er_idx);
            if (k == 4) t4 = cyc + 1;
        end
        @(negedge clk);
        dv = 1'b0; er = 1'b0; rxd = 8'h00;
        n = (len > MAXL) ? MAXL - 4 : ((len >= 4) ? len - 4 : 0);
        e.done_cyc  = cyc + 2;
        e.nb        = n;
        e.len       = 16'(n);
        e.first_cyc = (n > 0) ? t4 + 1 : -1;
        e.sof_ok    = 1'b1;
        e.st0       = model_status(f, er_idx, 1'b1, 1'b0);
        e.st1       = model_status(f, er_idx, 1'b0, 1'b0);
        e.st2       = model_status(f, er_idx, 1'b1, 1'b1);
        e.good      = (e.st0 == 4'b0000);
        if (e.good) exp_good++; else exp_bad++;
        for (int i = 0; i < n; i++) exp_bytes.push_back(f[i]);
        exp_q.push_back(e);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic check_pending();
        rec_t e, r;
        aux_t a;
        int   guard, mism;
        guard = 0;
        while ((res_q.size() < exp_q.size() || aux1_q.size() < exp_q.size() ||
                aux2_q.size() < exp_q.size()) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("done_count", res_q.size(), exp_q.size());
        check("done_count_nobcast", aux1_q.size(), exp_q.size());
        check("done_count_promisc", aux2_q.size(), exp_q.size());
        while (exp_q.size() > 0 && res_q.size() > 0) begin
            e = exp_q.pop_front();
            r = res_q.pop_front();
            check("status", r.st0, e.st0);
            check("good", r.good, e.good);
            check("len", r.len, e.len);
            check("nbytes", r.nb, e.nb);
            check("sof_marking", r.sof_ok, e.sof_ok);
            check("first_latency", r.first_cyc, e.first_cyc);
            check("done_latency", r.done_cyc, e.done_cyc);
            if (aux1_q.size() > 0) begin
                a = aux1_q.pop_front();
                check("status_nobcast", a.st, e.st1);
                check("good_nobcast", a.good, e.st1 == 4'b0000);
                check("len_nobcast", a.len, e.len);
            end
            if (aux2_q.size() > 0) begin
                a = aux2_q.pop_front();
                check("status_promisc", a.st, e.st2);
                check("good_promisc", a.good, e.st2 == 4'b0000);
                check("len_promisc", a.len, e.len);
            end
        end
        exp_q.delete(); res_q.delete(); aux1_q.delete(); aux2_q.delete();
        check("payload_count", rx_bytes.size(), exp_bytes.size());
        mism = 0;
        while (rx_bytes.size() > 0 && exp_bytes.size() > 0) begin
            if (rx_bytes.pop_front() != exp_bytes.pop_front()) mism++;
        end
        rx_bytes.delete(); exp_bytes.delete();
        check("payload_data", mism, 0);
        check("stream_same_all_params", stream_diff, 0);
        check("stat_good", stat_good, exp_good);
        check("stat_bad", stat_bad, exp_bad);
        check("frames_nobcast", d1_sg + d1_sb, exp_good + exp_bad);
        check("frames_promisc", d2_sg + d2_sb, exp_good + exp_bad);
    endtask

    initial begin : mon_main
        int     nb;
        bit     sof_ok;
        longint first;
        rec_t   r;
        nb = 0; sof_ok = 1'b1; first = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb = 0; sof_ok = 1'b1; first = -1;
            end else begin
                if (out_valid) begin
                    valid_cnt++;
                    rx_bytes.push_back(out_data);
                    if (out_sof !== (nb == 0)) sof_ok = 1'b0;
                    if (nb == 0) first = cyc;
                    nb++;
                end
                if (out_done) begin
                    done_cnt++;
                    r.st0 = out_status; r.st1 = '0; r.st2 = '0;
                    r.good = out_good; r.len = out_len; r.nb = nb;
                    r.first_cyc = first; r.done_cyc = cyc; r.sof_ok = sof_ok;
                    res_q.push_back(r);
                    nb = 0; sof_ok = 1'b1; first = -1;
                end
            end
        end
    end

    initial begin : mon_aux
        aux_t a;
        forever begin
            @(negedge clk);
            if ({d1_valid, d1_sof, d1_data} !== {out_valid, out_sof, out_data}) stream_diff++;
            if ({d2_valid, d2_sof, d2_data} !== {out_valid, out_sof, out_data}) stream_diff++;
            if (rst_n && d1_done) begin
                a.st = d1_status; a.good = d1_good; a.len = d1_len;
                aux1_q.push_back(a);
            end
            if (rst_n && d2_done) begin
                a.st = d2_status; a.good = d2_good; a.len = d2_len;
                aux2_q.push_back(a);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        byte unsigned f[$];
        logic [47:0]  da;
        int           sel, blen, er_idx, vc, dc;
        bit           good_fcs;

        rst_n = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", out_valid, 1'b0);
        check("reset_sof", out_sof, 1'b0);
        check("reset_done", out_done, 1'b0);
        check("reset_good", out_good, 1'b0);
        check("reset_status", out_status, 4'd0);
        check("reset_len", out_len, 16'd0);
        check("reset_data", out_data, 8'd0);
        check("reset_stat_good", stat_good, 16'd0);
        check("reset_stat_bad", stat_bad, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Unicast, corrupted copy, broadcast, foreign unicast.
        make_frame(f, MAC, 64, 1'b1);
        send_frame(f, 7, -1, 12);
        f[20] = f[20] ^ 8'h08;
        send_frame(f, 7, -1, 12);
        make_frame(f, 48'hFFFF_FFFF_FFFF, 64, 1'b1);
        send_frame(f, 7, -1, 12);
        make_frame(f, 48'h0200_0000_0001, 64, 1'b1);
        send_frame(f, 7, -1, 12);
        check_pending();

        // Runt then oversized frame separated by a single idle cycle.
        make_frame(f, MAC, 30, 1'b1);
        send_frame(f, 7, -1, 1);
        make_frame(f, MAC, 1600, 1'b1);
        send_frame(f, 7, -1, 12);
        check_pending();

        // Receive error at body byte 20.
        make_frame(f, MAC, 64, 1'b1);
        send_frame(f, 7, 20, 12);
        check_pending();

        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: da = MAC;
                1: da = 48'hFFFF_FFFF_FFFF;
                2: da = 48'h0200_0000_0001;
                default: da = {16'($urandom), $urandom};
            endcase
            blen     = $urandom_range(10, 160);
            good_fcs = ($urandom_range(0, 3) != 0);
            er_idx   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, blen - 1) : -1;
            make_frame(f, da, blen, good_fcs);
            send_frame(f, $urandom_range(1, 8), er_idx, $urandom_range(1, 4));
        end
        check_pending();

        // Reset at body byte 30, released while dv is still high.
        make_frame(f, MAC, 100, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            dv = 1'b1; rxd = 8'h55; er = 1'b0;
        end
        @(negedge clk);
        rxd = 8'hD5;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            rxd = f[k];
        end
        @(negedge clk);
        rxd = f[30];
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_done", out_done, 1'b0);
        check("midrst_len", out_len, 16'd0);
        check("midrst_stat_good", stat_good, 16'd0);
        check("midrst_stat_bad", stat_bad, 16'd0);
        rx_bytes.delete();
        exp_good = 0;
        exp_bad  = 0;
        for (int k = 31; k < 34; k++) begin
            @(negedge clk);
            rxd = f[k];
        end
        @(negedge clk);
        rxd = f[34];
        rst_n = 1'b1;
        vc = valid_cnt;
        dc = done_cnt;
        for (int k = 35; k < 100; k++) begin
            @(negedge clk);
            rxd = f[k];
        end
        @(negedge clk);
        dv = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_valid", valid_cnt - vc, 0);
        check("midrst_no_done", done_cnt - dc, 0);
        check("midrst_no_result", res_q.size(), 0);

        make_frame(f, MAC, 80, 1'b1);
        send_frame(f, 7, -1, 12);
        check_pending();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
